// File: rtl/ucie_ctl_sb_msg_scheduler_if.sv
// ----------------------------------------------------------------------------
// ucie_ctl_sb_msg_scheduler_if
// Bundles the requester-side and sideband-channel signals of the sideband
// message scheduler.
//
// Handshake:
//   i_req[k] is a level request and stays high until o_gnt[k] pulses.
//   o_gnt, o_done, o_timeout and o_rsp_drop are single-cycle pulses.
//   o_sb_msg_valid / i_sb_msg_in_valid qualify one 4-bit code per cycle.
//   The channel has no backpressure.
//
// Signals:
//   i_req             requester level requests (NREQ)
//   i_req_msg         per-requester message code, slice [4*k+3:4*k]
//   o_gnt             one-hot launch pulse
//   o_done            response-received pulse per requester
//   o_timeout         response-timeout pulse per requester
//   o_sb_msg          code driven to the partner
//   o_sb_msg_valid    qualifier for o_sb_msg
//   i_sb_msg_in       code received from the partner
//   i_sb_msg_in_valid qualifier for i_sb_msg_in
//   o_rsp_drop        pending partner response was overwritten
//   o_busy            a local request is outstanding
//   o_dbg_state       FSM state (0 = IDLE, 1 = WAIT_RSP)
//
// Modports:
//   master  scheduler side
//   slave   requesters plus channel side
// ----------------------------------------------------------------------------
interface ucie_ctl_sb_msg_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   i_req;
  logic [4*NREQ-1:0] i_req_msg;
  logic [NREQ-1:0]   o_gnt;
  logic [NREQ-1:0]   o_done;
  logic [NREQ-1:0]   o_timeout;
  logic [3:0]        o_sb_msg;
  logic              o_sb_msg_valid;
  logic [3:0]        i_sb_msg_in;
  logic              i_sb_msg_in_valid;
  logic              o_rsp_drop;
  logic              o_busy;
  logic              o_dbg_state;

  modport master (
    input  i_req, i_req_msg, i_sb_msg_in, i_sb_msg_in_valid,
    output o_gnt, o_done, o_timeout, o_sb_msg, o_sb_msg_valid,
           o_rsp_drop, o_busy, o_dbg_state
  );

  modport slave (
    output i_req, i_req_msg, i_sb_msg_in, i_sb_msg_in_valid,
    input  o_gnt, o_done, o_timeout, o_sb_msg, o_sb_msg_valid,
           o_rsp_drop, o_busy, o_dbg_state
  );
endinterface

// File: rtl/ucie_ctl_sb_msg_scheduler.sv
// ----------------------------------------------------------------------------
// ucie_ctl_sb_msg_scheduler
// Schedules UCIe sideband link-management messages. The block does four jobs:
//   - It round-robin arbitrates the local requesters.
//   - It allows only one outstanding local request at a time.
//   - It tracks the response to that request and raises a timeout if none
//     arrives.
//   - It automatically answers request messages that arrive from the partner.
//
// Message codes:
//   IDLE=0, ACT=1/2, RETRAIN=3/4, LNKERR=5/6, LNKRST=7/8
//   Each request code is odd and lies between 1 and 7. Its response code is
//   the request code plus 1.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   sb       ucie_ctl_sb_msg_scheduler_if.master (see the interface file)
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module ucie_ctl_sb_msg_scheduler #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  ucie_ctl_sb_msg_scheduler_if.master  sb
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMRW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [3:0]        code_q, code_d;
  logic [TMRW-1:0]   timer_q, timer_d;
  logic              pend_valid_q, pend_valid_d;
  logic [3:0]        pend_code_q, pend_code_d;

  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   timeout_q, timeout_d;
  logic [3:0]        sb_msg_q, sb_msg_d;
  logic              sb_valid_q, sb_valid_d;
  logic              drop_q, drop_d;
  logic              busy_q, busy_d;

  logic              win_found;
  logic [IDXW-1:0]   win_idx;
  logic [3:0]        win_code;
  int                slot;

  logic              send_pend;
  logic              rsp_match;
  logic              partner_req;

  // A request code is odd and at most 7.
  function automatic logic is_req_code(input logic [3:0] c);
    return c[0] && !c[3];
  endfunction

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] k);
    if (k == IDXW'(NREQ - 1)) return '0;
    else                      return k + IDXW'(1);
  endfunction

  // Pick the first eligible requester at or after the RR pointer.
  // The search wraps from NREQ-1 back to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_code  = '0;
    slot      = 0;
    for (int i = 0; i < NREQ; i++) begin
      slot = int'(rr_q) + i;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!win_found && sb.i_req[slot] &&
          is_req_code(sb.i_req_msg[4*slot +: 4])) begin
        win_found = 1'b1;
        win_idx   = IDXW'(slot);
        win_code  = sb.i_req_msg[4*slot +: 4];
      end
    end
  end

  // A nonzero gnt_q means a local message is on the channel this cycle.
  // The response slot that directly follows a local launch is reserved.
  // While that slot is reserved, a waiting response stays in the pending
  // register, where a newer partner request can still overwrite it.
  assign send_pend   = pend_valid_q && (gnt_q == '0);
  assign rsp_match   = sb.i_sb_msg_in_valid && (sb.i_sb_msg_in == (code_q + 4'd1));
  assign partner_req = sb.i_sb_msg_in_valid && is_req_code(sb.i_sb_msg_in);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    code_d       = code_q;
    timer_d      = timer_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    gnt_d        = '0;
    done_d       = '0;
    timeout_d    = '0;
    sb_msg_d     = '0;
    sb_valid_d   = 1'b0;
    drop_d       = 1'b0;

    if (send_pend) begin
      sb_msg_d     = pend_code_q;
      sb_valid_d   = 1'b1;
      pend_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // A waiting partner response takes the channel first.
        // In that case the local grant is deferred by one cycle.
        if (win_found && !pend_valid_q) begin
          gnt_d[win_idx] = 1'b1;
          sb_msg_d       = win_code;
          sb_valid_d     = 1'b1;
          owner_d        = win_idx;
          code_d         = win_code;
          timer_d        = '0;
          state_d        = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        timer_d = timer_q + TMRW'(1);
        // If a match and a timeout land in the same cycle, the match wins.
        if (rsp_match) begin
          done_d[owner_q] = 1'b1;
          rr_d            = next_idx(owner_q);
          timer_d         = '0;
          state_d         = IDLE;
        end else if (timer_q == TMRW'(TIMEOUT_CYC - 1)) begin
          timeout_d[owner_q] = 1'b1;
          rr_d               = next_idx(owner_q);
          timer_d            = '0;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A partner request always loads its response into the pending register.
    // The old value is reported as dropped only when it was not sent out
    // in this same cycle.
    if (partner_req) begin
      if (pend_valid_q && !send_pend) drop_d = 1'b1;
      pend_valid_d = 1'b1;
      pend_code_d  = sb.i_sb_msg_in + 4'd1;
    end
  end

  assign busy_d = (state_d == WAIT_RSP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      owner_q      <= '0;
      code_q       <= '0;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      timeout_q    <= '0;
      sb_msg_q     <= '0;
      sb_valid_q   <= 1'b0;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      code_q       <= code_d;
      timer_q      <= timer_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      sb_msg_q     <= sb_msg_d;
      sb_valid_q   <= sb_valid_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end

  assign sb.o_gnt          = gnt_q;
  assign sb.o_done         = done_q;
  assign sb.o_timeout      = timeout_q;
  assign sb.o_sb_msg       = sb_msg_q;
  assign sb.o_sb_msg_valid = sb_valid_q;
  assign sb.o_rsp_drop     = drop_q;
  assign sb.o_busy         = busy_q;
  assign sb.o_dbg_state    = state_q;

endmodule

// File: tb/tb_ucie_ctl_sb_msg_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ucie_ctl_sb_msg_scheduler
// Directed bench for the sideband message scheduler (NREQ=4, TIMEOUT_CYC=8).
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point. After tick() the outputs therefore show the decision made on
// the edge that just passed.
// ----------------------------------------------------------------------------
module tb_ucie_ctl_sb_msg_scheduler;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ucie_ctl_sb_msg_scheduler_if #(.NREQ(NREQ)) sb ();

  ucie_ctl_sb_msg_scheduler #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sb      (sb)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver and check tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic partner(input logic [3:0] code, input logic vld);
    sb.i_sb_msg_in       = code;
    sb.i_sb_msg_in_valid = vld;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},   32'(sb.o_gnt),          32'h0);
    chk({tag, "_valid"}, 32'(sb.o_sb_msg_valid), 32'h0);
    chk({tag, "_msg"},   32'(sb.o_sb_msg),       32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sb.i_req = '0;
    sb.i_req_msg = '0;
    partner(4'd0, 1'b0);

    // Reset state.
    tick(); tick();
    chk("rst_gnt",   32'(sb.o_gnt),          32'h0);
    chk("rst_done",  32'(sb.o_done),         32'h0);
    chk("rst_to",    32'(sb.o_timeout),      32'h0);
    chk("rst_msg",   32'(sb.o_sb_msg),       32'h0);
    chk("rst_valid", 32'(sb.o_sb_msg_valid), 32'h0);
    chk("rst_drop",  32'(sb.o_rsp_drop),     32'h0);
    chk("rst_busy",  32'(sb.o_busy),         32'h0);
    chk("rst_state", 32'(sb.o_dbg_state),    32'h0);
    #3 rst_n = 1'b1;

    // 1: single request from requester 1 (RETRAIN_REQ, code 3).
    sb.i_req = 4'b0010;
    sb.i_req_msg = 16'h0030;
    tick();
    chk("t1_gnt",   32'(sb.o_gnt),          32'h2);
    chk("t1_msg",   32'(sb.o_sb_msg),       32'h3);
    chk("t1_valid", 32'(sb.o_sb_msg_valid), 32'h1);
    chk("t1_busy",  32'(sb.o_busy),         32'h1);
    chk("t1_state", 32'(sb.o_dbg_state),    32'h1);
    sb.i_req = 4'b0000;
    tick();
    chk_quiet("t1_after");
    chk("t1_busy2", 32'(sb.o_busy), 32'h1);
    tick(); tick(); tick();
    chk("t1_nodone", 32'(sb.o_done), 32'h0);
    partner(4'd4, 1'b1);
    tick();
    chk("t1_done",  32'(sb.o_done), 32'h2);
    chk("t1_idle",  32'(sb.o_busy), 32'h0);
    partner(4'd0, 1'b0);
    tick();
    chk("t1_done_pulse", 32'(sb.o_done), 32'h0);
    chk("t1_busy_low",   32'(sb.o_busy), 32'h0);

    // 2: round-robin with all four requesters sending ACT_REQ (code 1).
    //    Reset first so that the pointer starts at 0.
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    sb.i_req = 4'b1111;
    sb.i_req_msg = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_gnt", 32'(sb.o_gnt), 32'(4'b0001 << (i % 4)));
      chk("t2_msg", 32'(sb.o_sb_msg), 32'h1);
      partner(4'd2, 1'b1);
      tick();
      chk("t2_done", 32'(sb.o_done), 32'(4'b0001 << (i % 4)));
      partner(4'd0, 1'b0);
    end
    sb.i_req = '0;
    sb.i_req_msg = '0;
    tick();
    // The RR pointer now sits at 1.

    // 3a: timeout. Requester 0 sends LNKERR_REQ (code 5) and gets no response.
    sb.i_req = 4'b0001;
    sb.i_req_msg = 16'h0005;
    tick();
    chk("t3_gnt", 32'(sb.o_gnt),    32'h1);
    chk("t3_msg", 32'(sb.o_sb_msg), 32'h5);
    sb.i_req = '0;
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("t3_early_to", 32'(sb.o_timeout), 32'h0);
    end
    tick();
    chk("t3_timeout", 32'(sb.o_timeout), 32'h1);
    chk("t3_no_done", 32'(sb.o_done),    32'h0);
    chk("t3_busy",    32'(sb.o_busy),    32'h0);
    tick();
    chk("t3_to_pulse", 32'(sb.o_timeout), 32'h0);

    // 3b: the response arrives in the same cycle as the timeout, so done wins.
    sb.i_req = 4'b0001;
    sb.i_req_msg = 16'h0005;
    tick();
    chk("t3b_gnt", 32'(sb.o_gnt), 32'h1);
    sb.i_req = '0;
    for (int i = 1; i < TO; i++) tick();
    partner(4'd6, 1'b1);
    tick();
    chk("t3b_done", 32'(sb.o_done),    32'h1);
    chk("t3b_noto", 32'(sb.o_timeout), 32'h0);
    partner(4'd0, 1'b0);
    tick();

    // 4a: the partner sends LNKRST_REQ (7) while a local request is waiting,
    //     so the scheduler answers with 8.
    sb.i_req = 4'b0100;
    sb.i_req_msg = 16'h0300;
    tick();
    chk("t4_gnt", 32'(sb.o_gnt),    32'h4);
    chk("t4_msg", 32'(sb.o_sb_msg), 32'h3);
    sb.i_req = '0;
    partner(4'd7, 1'b1);
    tick();
    chk("t4_load_drop", 32'(sb.o_rsp_drop), 32'h0);
    partner(4'd0, 1'b0);
    tick();
    chk("t4_auto_msg",   32'(sb.o_sb_msg),       32'h8);
    chk("t4_auto_valid", 32'(sb.o_sb_msg_valid), 32'h1);
    chk("t4_auto_gnt",   32'(sb.o_gnt),          32'h0);
    tick();
    chk_quiet("t4_after_auto");
    partner(4'd4, 1'b1);
    tick();
    chk("t4_done", 32'(sb.o_done), 32'h4);
    partner(4'd0, 1'b0);
    tick();

    // 4b: the partner sends 1 and then 3 while a local grant launches.
    //     Response 2 is dropped and response 4 is sent.
    sb.i_req = 4'b1000;
    sb.i_req_msg = 16'h7000;
    partner(4'd1, 1'b1);
    tick();
    chk("t4b_gnt",  32'(sb.o_gnt),      32'h8);
    chk("t4b_msg",  32'(sb.o_sb_msg),   32'h7);
    chk("t4b_drop0", 32'(sb.o_rsp_drop), 32'h0);
    sb.i_req = '0;
    partner(4'd3, 1'b1);
    tick();
    chk("t4b_drop",  32'(sb.o_rsp_drop),     32'h1);
    chk("t4b_quiet", 32'(sb.o_sb_msg_valid), 32'h0);
    partner(4'd0, 1'b0);
    tick();
    chk("t4b_rsp_msg",   32'(sb.o_sb_msg),       32'h4);
    chk("t4b_rsp_valid", 32'(sb.o_sb_msg_valid), 32'h1);
    chk("t4b_drop_pulse", 32'(sb.o_rsp_drop),    32'h0);
    tick();
    chk_quiet("t4b_after");
    partner(4'd8, 1'b1);
    tick();
    chk("t4b_done", 32'(sb.o_done), 32'h8);
    partner(4'd0, 1'b0);
    tick();
    // The RR pointer is back at 0.

    // 5: requester 0 holds an invalid code (2); requester 2 holds code 1.
    sb.i_req = 4'b0101;
    sb.i_req_msg = 16'h0102;
    tick();
    chk("t5_gnt", 32'(sb.o_gnt),    32'h4);
    chk("t5_msg", 32'(sb.o_sb_msg), 32'h1);
    sb.i_req = 4'b0001;
    partner(4'd2, 1'b1);
    tick();
    chk("t5_done", 32'(sb.o_done), 32'h4);
    partner(4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("t5_never");
    end
    sb.i_req = '0;
    sb.i_req_msg = '0;
    tick();

    // 6: reset while waiting for a response. Requester 1 sends code 3.
    sb.i_req = 4'b0010;
    sb.i_req_msg = 16'h0030;
    tick();
    chk("t6_gnt", 32'(sb.o_gnt), 32'h2);
    sb.i_req = '0;
    tick();
    chk("t6_busy", 32'(sb.o_busy), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_busy",  32'(sb.o_busy),      32'h0);
    chk("t6_async_state", 32'(sb.o_dbg_state), 32'h0);
    chk_quiet("t6_async");
    tick(); tick();
    chk("t6_no_done", 32'(sb.o_done),    32'h0);
    chk("t6_no_to",   32'(sb.o_timeout), 32'h0);
    #3 rst_n = 1'b1;
    sb.i_req = 4'b1111;
    sb.i_req_msg = 16'h1111;
    tick();
    chk("t6_first_gnt", 32'(sb.o_gnt), 32'h1);
    sb.i_req = '0;
    sb.i_req_msg = '0;
    tick();
    for (int i = 0; i < TO + 2; i++) begin
      tick();
      chk("t6_post_done", 32'(sb.o_done), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
